// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, redirect input and the F->D handoff.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_ready;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, d_valid, d_pc, d_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, d_ready
  );

  // Environment side (imem, branch unit, D-stage register)
  modport slave (
    input  imem_req_valid, imem_req_addr, d_valid, d_pc, d_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, d_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC generation, credit-based imem requests, in-order
// (pc, instr) buffer feeding the D-stage register, redirect flush with stale-response drop.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic       clk,
  input logic       reset,
  if_fetch_unit_if.master bus
);

  localparam int unsigned  PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned  CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(BUF_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0] infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;
  logic [31:0]      infl_pc_q [BUF_DEPTH];
  logic [31:0]      infl_pc_d [BUF_DEPTH];
  logic [31:0]      buf_pc_q [BUF_DEPTH];
  logic [31:0]      buf_pc_d [BUF_DEPTH];
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [31:0]      buf_instr_d [BUF_DEPTH];

  logic           has_entry, pop, credit, issue, rsp, push;
  logic [CNT_W:0] occ;

  // Handshake decode and issue credit
  always_comb begin
    has_entry = (count_q != '0);
    pop       = has_entry && !bus.redirect_valid && bus.d_ready;
    // A same-cycle pop frees a slot before any new response can land (latency >= 1),
    // which is what sustains one instruction per cycle at BUF_DEPTH = 2.
    occ       = {1'b0, outst_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
    credit    = reset && !bus.redirect_valid && (occ < DEPTH);
    issue     = credit && bus.imem_req_ready;
    rsp       = bus.imem_rsp_valid && (outst_q != '0);
    push      = rsp && (drop_q == '0) && !bus.redirect_valid;
  end

  // Next-state: PC, in-flight tracking, drop counter, output buffer
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    outst_d     = outst_q + CNT_W'(issue) - CNT_W'(rsp);
    drop_d      = drop_q;
    count_d     = count_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    infl_wr_d   = infl_wr_q;
    infl_rd_d   = infl_rd_q;
    infl_pc_d   = infl_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    // Every response, kept or dropped, retires the oldest in-flight pc
    if (issue) begin
      infl_pc_d[infl_wr_q] = fetch_pc_q;
      infl_wr_d            = infl_wr_q + 1'b1;
      fetch_pc_d           = fetch_pc_q + 32'd4;
    end
    if (rsp) begin
      infl_rd_d = infl_rd_q + 1'b1;
    end

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      drop_d     = outst_d;
      count_d    = '0;
      wr_d       = '0;
      rd_d       = '0;
    end else begin
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        buf_pc_d[wr_q]    = infl_pc_q[infl_rd_q];
        buf_instr_d[wr_q] = bus.imem_rsp_data;
        wr_d              = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      infl_wr_q   <= '0;
      infl_rd_q   <= '0;
      infl_pc_q   <= '{default: '0};
      buf_pc_q    <= '{default: '0};
      buf_instr_q <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      infl_wr_q   <= infl_wr_d;
      infl_rd_q   <= infl_rd_d;
      infl_pc_q   <= infl_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // Outputs: head entry, nop and fetch_pc when empty, suppressed during redirect
  always_comb begin
    bus.imem_req_valid = credit;
    bus.imem_req_addr  = fetch_pc_q;
    bus.d_valid        = has_entry && !bus.redirect_valid;
    bus.d_pc           = has_entry ? buf_pc_q[rd_q] : fetch_pc_q;
    bus.d_instr        = (has_entry && !bus.redirect_valid) ? buf_instr_q[rd_q] : '0;
  end

  // Credit must prevent a response landing on a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && (count_q == CNT_W'(BUF_DEPTH)) && !pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: golden sequential PC stream, in-order imem model.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(32'h0000_3000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int          n_vec = 0;
  int          n_err = 0;
  rsp_t        pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          first_req_cyc = -1;
  int          first_dv_cyc = -1;
  int          ndv = 0;
  bit          saw_dv;
  logic [31:0] seen_pc;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic topup;
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
  endtask

  task automatic idle_inputs;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.d_ready        = 1'b0;
  endtask

  // One clock: drive at negedge, sample/check 1ns later, posedge follows
  task automatic cycle(input bit rdy, input bit dr, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend_q[0].data;
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    bus.imem_req_ready = rdy;
    bus.d_ready        = dr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    topup();
    if (redir) begin
      chk("redir_dvalid", {31'b0, bus.d_valid}, 32'd0);
      chk("redir_instr", bus.d_instr, 32'd0);
      chk("redir_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    end else if (bus.d_valid) begin
      chk("d_pc", bus.d_pc, exp_q[0]);
      chk("d_instr", bus.d_instr, word_of(exp_q[0]));
      saw_dv  = 1'b1;
      seen_pc = bus.d_pc;
      ndv++;
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      if (dr) void'(exp_q.pop_front());
    end else begin
      chk("nop_instr", bus.d_instr, 32'd0);
    end
    if (bus.imem_req_valid && rdy) begin
      int d;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_q.push_back('{d, word_of(bus.imem_req_addr)});
      chk("addr_align", {30'b0, bus.imem_req_addr[1:0]}, 32'd0);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (redir) begin
      exp_q.delete();
      gen_pc = {rpc[31:2], 2'b00};
      topup();
    end
  endtask

  // Assert reset at the current time, check outputs at once, release at a negedge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    idle_inputs();
    pend_q.delete();
    exp_q.delete();
    last_due = cyc;
    #1;
    chk({tag, "_dvalid"}, {31'b0, bus.d_valid}, 32'd0);
    chk({tag, "_dpc"}, bus.d_pc, 32'h0000_3000);
    chk({tag, "_dinstr"}, bus.d_instr, 32'd0);
    chk({tag, "_reqv"}, {31'b0, bus.imem_req_valid}, 32'd0);
    repeat (2) @(negedge clk);
    gen_pc        = 32'h0000_3000;
    topup();
    first_req_cyc = -1;
    first_dv_cyc  = -1;
    ndv           = 0;
    reset         = 1'b1;
  endtask

  task automatic wait_dvalid(input string tag, input logic [31:0] exp);
    int k;
    k      = 0;
    saw_dv = 1'b0;
    while (!saw_dv && k < 40) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      k++;
    end
    chk(tag, saw_dv ? seen_pc : 32'hDEAD_DEAD, exp);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset("rst");

    // Streaming from reset with a 1-cycle imem
    lat_min = 1; lat_max = 1;
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t1_latency", 32'(first_dv_cyc - first_req_cyc), 32'd2);
    chk("t1_count", 32'(ndv), 32'd3);

    // Five-cycle stall after the first instruction
    @(negedge clk); #2;
    do_reset("rst2");
    wait_dvalid("t2_first", 32'h0000_3000);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t2_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("t2_head", bus.d_pc, 32'h0000_3004);
    ndv = 0;
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t2_stream", 32'(ndv), 32'd10);

    // Redirect with fetches in flight (2-cycle imem)
    @(negedge clk); #2;
    do_reset("rst3");
    lat_min = 2; lat_max = 2;
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_4002);
    wait_dvalid("t3_first", 32'h0000_4000);

    // Back-to-back redirects
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_5000);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_6000);
    wait_dvalid("t4_first", 32'h0000_6000);

    // PC wrap past the top of the address space
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Random ready, latency and redirects
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
            $urandom_range(39, 0) == 0, $urandom);
    end
    lat_min = 1; lat_max = 1;
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Reset asserted between edges mid-stream
    repeat (6) cycle(1'b1, $urandom_range(1, 0) != 0, 1'b0, 32'd0);
    #2;
    do_reset("t6");
    wait_dvalid("t6_first", 32'h0000_3000);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
